// File: rtl/uart_rx16.sv
// uart_rx16: 16x-oversampling UART receiver (8N1 by default). Ticks come from rising edges of baud16.
// Optional: define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx16 #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic                   baud16_q;
  logic                   tick;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxd_s;
  logic [3:0]             tcnt_q, tcnt_d;
  logic [IDX_W-1:0]       bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  assign tick   = baud16 & ~baud16_q;
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  assign rxd_s  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      baud16_q    <= 1'b1;
      sync_q      <= '1;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud16_q    <= baud16;
      sync_q      <= sync_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Frame FSM; everything advances only on tick cycles so a stalled baud16 freezes it.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        S_HUNT: if (rxd_s) state_d = S_IDLE;
        S_IDLE: begin
          if (!rxd_s) begin
            tcnt_d  = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd7) begin
            if (!rxd_s) begin
              tcnt_d  = '0;
              bidx_d  = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bidx_d  = bidx_q + IDX_W'(1);
            if (bidx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            par_bad_d = (^shift_q) ^ rxd_s;
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                parity_err_d = 1'b1;
              end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end
`else
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
`endif
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_HUNT;
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
    busy_d = (state_d == S_START) || (state_d == S_DATA) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx16.sv
// Directed bench for uart_rx16: frame table plus hand sequences for reset, back-to-back and stalled baud.
module tb_uart_rx16;

  localparam int BIT_CLK = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       baud16;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  logic [2:0] bdiv = 3'd0;
  logic       baud_run = 1'b1;
  int         cyc = 0;

  uart_rx16 dut (
    .clk       (clk),
    .rst       (rst),
    .baud16    (baud16),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // baud16: square wave of period 8 clk, freezable to emulate a stuck generator
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (baud_run) bdiv <= bdiv + 3'd1;
  end
  assign baud16 = bdiv[2];

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         long_cnt  = 0;
  int         perr_cnt  = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] vq_data[$];
  int         vq_cyc[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      vq_data.push_back(rx_data);
      vq_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if (rx_valid === 1'b1 && valid_prev) long_cnt <= long_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
    valid_prev <= (rx_valid === 1'b1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_data(d);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  typedef struct {
    logic       false_start;
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int v0, f0, t0, q0, bcnt;

    vecs[0] = '{1'b0, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[1] = '{1'b0, 8'hA3, 1'b0, 1'b0, 8'h55, 1'b1};
    vecs[2] = '{1'b0, 8'h12, 1'b1, 1'b1, 8'h12, 1'b0};
    vecs[3] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};

    // Reset with the line held low: receiver must stay in HUNT
    rst = 1'b1;
    rxd = 1'b0;
    wait_clk(4);
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bcnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bcnt++;
    end
    check("line-low busy cycles", 32'(bcnt), 32'h0);
    check("line-low rx_valid", 32'(valid_cnt - v0), 32'h0);
    check("line-low frame_err", 32'(ferr_cnt - f0), 32'h0);
    rxd = 1'b1;
    wait_clk(200);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      q0 = vq_cyc.size();
      rxd = 1'b1;
      wait_clk(64);
      if (vecs[i].false_start) begin
        rxd = 1'b0;
        wait_clk(24);
        rxd = 1'b1;
        wait_clk(76);
        check($sformatf("vec%0d false-start busy", i), 32'(busy), 32'h0);
        wait_clk(100);
      end
      t0 = cyc;
      send_frame(vecs[i].data, vecs[i].stop);
      rxd = 1'b1;
      wait_clk(300);
      check($sformatf("vec%0d rx_valid count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d frame_err count", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      if (i == 0 && vq_cyc.size() > q0) begin
        t0 = vq_cyc[q0] - t0;
        check("vec0 latency in window", 32'((t0 >= 1215) && (t0 <= 1230)), 32'h1);
      end
    end

    // Back-to-back frames with zero idle gap
    q0 = vq_data.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rxd = 1'b1;
    wait_clk(300);
    check("b2b pulse count", 32'(vq_data.size() - q0), 32'h2);
    if (vq_data.size() >= q0 + 2) begin
      check("b2b first data", 32'(vq_data[q0]), 32'h00);
      check("b2b second data", 32'(vq_data[q0+1]), 32'hFF);
      check("b2b spacing", 32'(vq_cyc[q0+1] - vq_cyc[q0]), 32'd1280);
    end

    // Reset after four data bits of 0x81
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    rxd = 1'b1;
    wait_clk(400);
    check("midreset rx_valid", 32'(valid_cnt - v0), 32'h0);
    check("midreset frame_err", 32'(ferr_cnt - f0), 32'h0);
    check("midreset rx_data", 32'(rx_data), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    send_frame(8'h3C, 1'b1);
    rxd = 1'b1;
    wait_clk(300);
    check("post-reset rx_valid", 32'(valid_cnt - v0), 32'h1);
    check("post-reset rx_data", 32'(rx_data), 32'h3C);

    // Stalled baud16: no ticks, no activity
    baud_run = 1'b0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bcnt = 0;
    rxd = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bcnt++;
    end
    rxd = 1'b1;
    wait_clk(50);
    check("stalled busy cycles", 32'(bcnt), 32'h0);
    check("stalled rx_valid", 32'(valid_cnt - v0), 32'h0);
    check("stalled frame_err", 32'(ferr_cnt - f0), 32'h0);
    baud_run = 1'b1;
    wait_clk(200);

`ifdef UART_RX_PARITY_EN
    v0 = valid_cnt;
    f0 = perr_cnt;
    send_data(8'h07);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_clk(300);
    check("parity good rx_valid", 32'(valid_cnt - v0), 32'h1);
    check("parity good rx_data", 32'(rx_data), 32'h07);
    check("parity good parity_err", 32'(perr_cnt - f0), 32'h0);
    v0 = valid_cnt;
    f0 = perr_cnt;
    send_data(8'h07);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_clk(300);
    check("parity bad rx_valid", 32'(valid_cnt - v0), 32'h0);
    check("parity bad parity_err", 32'(perr_cnt - f0), 32'h1);
`endif

    check("valid and frame_err together", 32'(both_cnt), 32'h0);
    check("rx_valid longer than 1 clk", 32'(long_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx16.md
Name: uart_rx16

Overview:
- 16x-oversampling UART receiver that sits on the RX side of the serial link.
- Timing comes from the existing 16x baud square wave, taken on the `baud16` input; the receiver makes its own one-cycle tick from each rising edge of that wave.
- Recovers 8N1 frames from `rxd` (asynchronous pin) and presents each byte as a one-cycle valid pulse to the system-clock logic, e.g. the frequency-measure command parser.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.
- SYNC_STAGES, 2, flip-flop stages in the `rxd` synchroniser; minimum 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- baud16  input  1  16x baud square wave from the baud generator, synchronous to clk.
- rxd  input  1  serial line; idle high; asynchronous.
- rx_data  output  DATA_BITS  last good byte; held until the next good frame.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- frame_err  output  1  one-clk pulse on a bad stop bit.
- busy  output  1  high in START, DATA and STOP states.

Behaviour:
- Tick generation:
  - `baud16_d` is a registered copy of `baud16`, reset value 1.
  - tick = baud16 & ~baud16_d, a one-clk pulse.
  - All sampling and counting below happens only on tick cycles.
- Synchroniser:
  - `rxd` passes through SYNC_STAGES flops; all stages reset to 1.
  - `rxd_s` is the last stage.
- Counters:
  - 4-bit tick counter `tcnt`.
  - Bit index wide enough for DATA_BITS-1.
  - Shift register, DATA_BITS wide, shifting right so the first received bit ends at bit 0.
- States:
  - HUNT (reset state): on a tick with rxd_s==1, go to IDLE. This stops a line held low at reset from being taken as a start bit.
  - IDLE: on a tick with rxd_s==0, set tcnt:=0 and go to START.
  - START: each tick, tcnt:=tcnt+1. On the tick where tcnt==7 (mid start bit), sample:
    - rxd_s==0: set tcnt:=0, bit index:=0, go to DATA.
    - rxd_s==1: false start; go to IDLE with no outputs.
  - DATA: each tick, tcnt:=tcnt+1 (wraps 15->0). On the tick where tcnt==15:
    - shift in rxd_s and increment the bit index;
    - after bit DATA_BITS-1, go to STOP.
  - STOP: on the tick where tcnt==15, sample:
    - rxd_s==1: rx_data <= shift register; rx_valid=1 for the next clk only; go to IDLE.
    - rxd_s==0: frame_err=1 for the next clk only; rx_data unchanged; go to HUNT.
- Output timing:
  - Latency is 1 clk from the stop-sample tick cycle to the rx_valid / frame_err pulse.
  - rx_valid and frame_err are never high together.
- busy is a registered function of state.
- Back-to-back frames: the IDLE exit happens on the first tick after the stop sample. A start bit that begins right after the stop bit must be received correctly, i.e. the receiver tolerates an idle gap of 0 bits.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - state=HUNT; counters 0.
- Reset mid-frame: the partial frame is discarded with no pulse. The receiver re-enters HUNT and must see the line high before it accepts a start bit.
- baud16 stuck at either level: no ticks occur, the FSM freezes, and no spurious outputs are produced.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP; it samples the parity bit at tcnt==15.
  - An added output `parity_err` (1 bit, reset 0) checks even parity: the XOR of the data bits and the parity bit must be 0.
  - On mismatch with a good stop bit: parity_err pulses for 1 clk, rx_valid stays 0, rx_data is unchanged, and the FSM goes to IDLE.
  - A bad stop bit still gives frame_err only.
- When undefined: no PARITY state and no parity_err port; frame is 8N1.

Test Plan:
All cases use baud16 as a square wave of period 8 clk, so 1 tick = 8 clk and 1 bit = 128 clk.
- Reset, line low: rst high for 4 clk with rxd=0, then rxd held low 600 clk, then high.
  - Required: no rx_valid, no frame_err; busy=0 throughout; state leaves HUNT only after rxd goes high.
- Single frame: send 0x55 as 8N1.
  - Required: rx_data=0x55; rx_valid high for exactly 1 clk, about 1224 clk after the start edge; frame_err=0.
- False start: rxd low for 24 clk (3 ticks), then high.
  - Required: no pulses; busy drops within 8 ticks; the next frame 0xA5 is received correctly.
- Bad stop: send 0x55, then 0xA3 with the stop bit driven 0, then release the line high.
  - Required: one frame_err pulse, rx_data stays 0x55, no rx_valid for 0xA3; a following frame 0x12 is received.
- Back-to-back: send 0x00 then 0xFF with zero idle gap.
  - Required: two rx_valid pulses with rx_data 0x00 then 0xFF, spaced 1280 clk.
- Reset mid-frame: assert rst after 4 data bits of 0x81.
  - Required: no pulse. After idle, 0x3C is received correctly.
- With UART_RX_PARITY_EN defined:
  - 0x07 sent with parity bit 1 -> rx_valid, rx_data=0x07.
  - 0x07 sent with parity bit 0 -> parity_err pulse, no rx_valid.
